// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and index-width helper for the write-back arbiter
package wb_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 32;

  // Width needed to hold a requester index 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: valid vector + start pointer -> one-hot grant
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  // Scan from ptr upward, wrapping N-1 -> 0; the first valid requester wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_v  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IW'(idx);
      if (enable && !found && valid[idx_v]) begin
        found        = 1'b1;
        grant[idx_v] = 1'b1;
        winner       = idx_v;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back port arbiter with optional pending-write scoreboard (WB_ARBITER_SCOREBOARD_EN)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NREQ   = NREQ_DEF
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic [NREQ-1:0]        w_req_valid,
  input  logic [NREQ*AWIDTH-1:0] w_req_rd,
  input  logic [NREQ*DWIDTH-1:0] w_req_data,
  output logic [NREQ-1:0]        w_req_ready,
  input  logic                   w_hold,
  output logic                   w_rf_we,
  output logic [AWIDTH-1:0]      w_rf_addr,
  output logic [DWIDTH-1:0]      w_rf_data,
  input  logic                   w_issue_valid,
  input  logic [AWIDTH-1:0]      w_issue_rd,
  input  logic [AWIDTH-1:0]      w_rs1,
  input  logic [AWIDTH-1:0]      w_rs2,
  output logic                   w_rs1_busy,
  output logic                   w_rs2_busy
);

  localparam int IW = idx_width(NREQ);

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     winner;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic [AWIDTH-1:0] sel_rd;
  logic [DWIDTH-1:0] sel_data;

  // Grants are suppressed while held or in reset, so ready is all-zero then.
  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .valid  (w_req_valid),
    .ptr    (ptr),
    .enable (~w_hold & ~w_rst),
    .grant  (grant),
    .winner (winner),
    .found  (found)
  );

  assign w_req_ready = grant;

  // One-hot mux of the winning requester's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = w_req_rd[i*AWIDTH +: AWIDTH];
        sel_data = w_req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Pointer moves to one past the winner on a grant, otherwise holds.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Register the accepted request; rd=0 is consumed but never written.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_rf_we   <= 1'b0;
      w_rf_addr <= '0;
      w_rf_data <= '0;
    end else if (found) begin
      w_rf_we   <= (sel_rd != '0);
      w_rf_addr <= sel_rd;
      w_rf_data <= sel_data;
    end else begin
      w_rf_we   <= 1'b0;
    end
  end

`ifdef WB_ARBITER_SCOREBOARD_EN
  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0] pend;

  // Clear on write-back, then set on issue so a same-edge collision leaves it set.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      pend <= '0;
    end else begin
      if (w_rf_we) pend[w_rf_addr] <= 1'b0;
      if (w_issue_valid && (w_issue_rd != '0)) pend[w_issue_rd] <= 1'b1;
    end
  end

  // A register being written this cycle is bypassed by the register file, so not busy.
  assign w_rs1_busy = (w_rs1 != '0) & pend[w_rs1] & ~(w_rf_we & (w_rf_addr == w_rs1));
  assign w_rs2_busy = (w_rs2 != '0) & pend[w_rs2] & ~(w_rf_we & (w_rf_addr == w_rs2));
`else
  logic unused_sb;

  assign unused_sb  = ^{w_issue_valid, w_issue_rd, w_rs1, w_rs2};
  assign w_rs1_busy = 1'b0;
  assign w_rs2_busy = 1'b0;
`endif

endmodule
